uart_data_rx: RTL and testbench
===============================

Name: uart_data_rx

Overview:
- Receive-side counterpart of the multi-byte UART transmitter.
- Deserialises a stream of 8N1 UART bytes on one line and assembles DATA_WIDTH/8 consecutive bytes into one word.
- Presents the word with a one-cycle rx_done strobe.
- Sits between the board RX pin and a word-wide consumer; uses the same baud_set encoding and byte-order parameter as the transmitter.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8 and at least 8.
- MSB_FIRST, 0, 0: first received byte lands in data[7:0]; 1: first received byte lands in data[DATA_WIDTH-1 -: 8].
- CLK_FREQ, 50_000_000, clk frequency in Hz, used for baud divisors.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- uart_rx  in  1  asynchronous serial input; idle high.
- baud_set  in  3  0:9600, 1:19200, 2:38400, 3:57600, 4:115200, 5-7:115200.
- data  out  DATA_WIDTH  last completed word.
- rx_done  out  1  one-cycle strobe: data updated this cycle.
- frame_error  out  1  one-cycle strobe: bad stop bit, partial word discarded.
- uart_state  out  1  high from start-bit detect of the first byte until the word completes or aborts.

Behaviour:
- Clock and reset:
  - Single clock; reset is synchronous and active-high.
  - Reset values: data=0, rx_done=0, frame_error=0, uart_state=0. Internal state returns to IDLE, byte counter=0, synchroniser flops=1.
  - Reset mid-frame aborts immediately; no strobe is generated.
- Input synchronisation: uart_rx passes through a 2-FF synchroniser plus one history flop. A falling edge is sync=0 and prev=1.
- Baud divisor:
  - BAUD_DIV = CLK_FREQ/baud, integer truncation (5208, 2604, 1302, 868, 434 at 50 MHz).
  - baud_set is latched at each start-bit detect and held for that byte; changes mid-byte have no effect.
- Byte FSM:
  - IDLE:
    - On a falling edge, load bit counter=0, clear the baud counter, go to START.
  - START:
    - At baud count BAUD_DIV/2-1, sample the line.
    - If the line is 1: false start; go to IDLE. Byte counter and uart_state are unchanged unless byte counter=0, in which case uart_state drops.
    - If the line is 0: go to DATA.
  - DATA:
    - Sample every BAUD_DIV cycles from mid-start.
    - 8 bits, LSB first, shifted into the byte register.
    - After bit 7, go to STOP.
  - STOP:
    - Sample at mid-stop.
    - If 1: byte accepted; go to IDLE immediately so back-to-back frames with a one-stop-bit gap are caught.
    - If 0: frame_error pulses the next cycle; byte counter clears; uart_state drops; go to WAIT_HIGH.
  - WAIT_HIGH:
    - Stay until the synchronised line is 1, then go to IDLE. This prevents break conditions from re-triggering.
- Word assembly:
  - Each accepted byte is written into the assembly register at slot byte_cnt (MSB_FIRST=0) or NBYTES-1-byte_cnt (MSB_FIRST=1). byte_cnt then increments.
  - When byte NBYTES-1 is accepted, data is loaded with the completed word in the same cycle, then rx_done=1 for exactly one cycle. byte_cnt wraps to 0 and uart_state drops.
  - Latency: rx_done rises 1 clk after the mid-stop sample of the last byte.
- data holds its value between rx_done strobes. It is never partially updated, including on frame error.
- rx_done and frame_error are never both high in the same cycle.

Optional Feature:
- Macro: UART_DATA_RX_TIMEOUT_EN.
- Defined:
  - An inter-byte idle counter runs while byte_cnt is nonzero and the FSM is in IDLE.
  - If it reaches 16*BAUD_DIV cycles with no falling edge, the partial word is discarded: byte_cnt=0, uart_state drops, frame_error pulses for one cycle.
  - The counter clears on every falling edge.
- Not defined:
  - No counter is present; a partial word waits indefinitely for its remaining bytes.

Test Plan:
- Word assembly, MSB_FIRST=0: baud_set=4, drive bytes 0x67,0x45,0x23,0x01 back to back -> exactly one rx_done, data=0x01234567, uart_state low afterwards.
- Word assembly, MSB_FIRST=1: baud_set=4, same byte sequence -> data=0x67452301.
- Glitch rejection: uart_rx low pulse of 100 clk at baud_set=4 (under 217 clk) -> no state change, no strobes.
- Frame error recovery: second byte has stop bit 0 -> frame_error pulse, no rx_done, data unchanged. Next full 4-byte word 0x12345678 (sent LSB byte first) -> rx_done, data=0x12345678.
- Mid-frame reset: assert reset during the third byte, deassert, send 0x89,0x67,0x45,0x23 at baud_set=0 -> data=0x23456789; no spurious rx_done.
- Timeout (macro defined): send 2 bytes, idle 20 bit times -> frame_error after 16*434 clk idle. Next 4-byte word assembles correctly. Without the macro, the same stimulus gives no frame_error.

Source files
------------

// File: rtl/uart_data_rx_if.sv
// uart_data_rx_if: serial line, baud select and word-side outputs of the
// multi-byte UART receiver. The receiver uses the slave modport; the
// driving side (line driver / consumer) uses the master modport.
interface uart_data_rx_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  uart_rx;
    logic [2:0]            baud_set;
    logic [DATA_WIDTH-1:0] data;
    logic                  rx_done;
    logic                  frame_error;
    logic                  uart_state;

    modport master (
        output uart_rx, baud_set,
        input  data, rx_done, frame_error, uart_state
    );

    modport slave (
        input  uart_rx, baud_set,
        output data, rx_done, frame_error, uart_state
    );
endinterface

// File: rtl/uart_data_rx.sv
// uart_data_rx: 8N1 UART receiver that assembles DATA_WIDTH/8 consecutive
// bytes into one word and strobes rx_done when the word completes.
// Optional macro UART_DATA_RX_TIMEOUT_EN: discards a partial word after
// 16 bit times of inter-byte idle and reports it on frame_error.
module uart_data_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int MSB_FIRST  = 0,
    parameter int CLK_FREQ   = 50_000_000
) (
    input logic          clk,
    input logic          reset,
    uart_data_rx_if.slave bus
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int DIV0   = CLK_FREQ / 9600;
    localparam int DIV1   = CLK_FREQ / 19200;
    localparam int DIV2   = CLK_FREQ / 38400;
    localparam int DIV3   = CLK_FREQ / 57600;
    localparam int DIV4   = CLK_FREQ / 115200;
    localparam int CW     = $clog2(DIV0 + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t                state, state_nx;
    logic                  rx_meta, rx_sync, rx_prev;
    logic                  fall;
    logic [2:0]            baud_sel;
    logic [CW-1:0]         baud_div;
    logic [CW-1:0]         baud_cnt;
    logic                  half_hit, full_hit;
    logic [2:0]            bit_cnt;
    logic [7:0]            shreg;
    logic [BCW-1:0]        byte_cnt;
    logic [BCW-1:0]        slot;
    logic                  last_byte;
    logic [DATA_WIDTH-1:0] asm_q;
    logic [DATA_WIDTH-1:0] word_nx;
    logic                  start_det, start_bad, start_ok;
    logic                  bit_smp, stop_ok, stop_bad;
    logic                  timeout;

    // Two-flop synchroniser plus history flop for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= bus.uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall = rx_prev & ~rx_sync;

    // Divisor for the baud rate latched at this byte's start bit
    always_comb begin
        case (baud_sel)
            3'd0:    baud_div = CW'(DIV0);
            3'd1:    baud_div = CW'(DIV1);
            3'd2:    baud_div = CW'(DIV2);
            3'd3:    baud_div = CW'(DIV3);
            default: baud_div = CW'(DIV4);
        endcase
    end

    assign half_hit  = (baud_cnt == (baud_div >> 1) - 1'b1);
    assign full_hit  = (baud_cnt == baud_div - 1'b1);
    assign last_byte = (byte_cnt == BCW'(NBYTES - 1));
    assign slot      = (MSB_FIRST != 0) ? BCW'(NBYTES - 1) - byte_cnt : byte_cnt;

    // Byte FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Byte FSM next state and per-cycle sample strobes
    always_comb begin
        state_nx  = state;
        start_det = 1'b0;
        start_bad = 1'b0;
        start_ok  = 1'b0;
        bit_smp   = 1'b0;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall) begin
                    start_det = 1'b1;
                    state_nx  = S_START;
                end
            end
            S_START: begin
                if (half_hit) begin
                    if (rx_sync) begin
                        start_bad = 1'b1;
                        state_nx  = S_IDLE;
                    end else begin
                        start_ok = 1'b1;
                        state_nx = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (full_hit) begin
                    bit_smp = 1'b1;
                    if (bit_cnt == 3'd7) state_nx = S_STOP;
                end
            end
            S_STOP: begin
                if (full_hit) begin
                    if (rx_sync) begin
                        stop_ok  = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_nx = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rx_sync) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Assembly register with the just-received byte dropped into its slot
    always_comb begin
        word_nx = asm_q;
        for (int i = 0; i < NBYTES; i++) begin
            if (BCW'(i) == slot) word_nx[i*8 +: 8] = shreg;
        end
    end

`ifdef UART_DATA_RX_TIMEOUT_EN
    logic [CW+3:0] to_cnt;
    logic          to_run;

    assign to_run  = (state == S_IDLE) && (byte_cnt != '0) && !fall;
    assign timeout = to_run && (to_cnt == {baud_div, 4'b0000} - 1'b1);

    // Inter-byte idle counter; any falling edge restarts it
    always_ff @(posedge clk) begin
        if (reset || !to_run || timeout) to_cnt <= '0;
        else                             to_cnt <= to_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    // Bit timing, byte shifting, word assembly and output strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_sel        <= 3'd0;
            baud_cnt        <= '0;
            bit_cnt         <= 3'd0;
            shreg           <= 8'h00;
            byte_cnt        <= '0;
            asm_q           <= '0;
            bus.data        <= '0;
            bus.rx_done     <= 1'b0;
            bus.frame_error <= 1'b0;
            bus.uart_state  <= 1'b0;
        end else begin
            bus.rx_done     <= 1'b0;
            bus.frame_error <= 1'b0;

            if (state == S_IDLE || start_ok || bit_smp) baud_cnt <= '0;
            else                                        baud_cnt <= baud_cnt + 1'b1;

            if (start_det) begin
                bit_cnt        <= 3'd0;
                baud_sel       <= bus.baud_set;
                bus.uart_state <= 1'b1;
            end

            if (start_bad && byte_cnt == '0) bus.uart_state <= 1'b0;

            if (bit_smp) begin
                shreg   <= {rx_sync, shreg[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (stop_ok) begin
                if (last_byte) begin
                    bus.data       <= word_nx;
                    bus.rx_done    <= 1'b1;
                    byte_cnt       <= '0;
                    bus.uart_state <= 1'b0;
                end else begin
                    asm_q    <= word_nx;
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end

            if (stop_bad || timeout) begin
                bus.frame_error <= 1'b1;
                byte_cnt        <= '0;
                bus.uart_state  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_data_rx.sv
// tb_uart_data_rx: drives one serial line into an LSB-first and an
// MSB-first receiver; expected words go into per-DUT scoreboard queues and
// a monitor pops them on every rx_done.
module tb_uart_data_rx;
    localparam int CLK = 5_000_000;
    localparam int B0  = 520;   // 5 MHz / 9600
    localparam int B4  = 43;    // 5 MHz / 115200

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_line = 1'b1;
    logic [2:0] baud = 3'd4;

    int checks = 0;
    int errors = 0;
    int rx_cnt0 = 0, rx_cnt1 = 0;
    int fe_cnt0 = 0, fe_cnt1 = 0;
    int rx_snap0, rx_snap1, fe_snap0, fe_snap1;

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    uart_data_rx_if #(.DATA_WIDTH(32)) bus0();
    uart_data_rx_if #(.DATA_WIDTH(32)) bus1();

    assign bus0.uart_rx  = rx_line;
    assign bus0.baud_set = baud;
    assign bus1.uart_rx  = rx_line;
    assign bus1.baud_set = baud;

    uart_data_rx #(.DATA_WIDTH(32), .MSB_FIRST(0), .CLK_FREQ(CLK)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    uart_data_rx #(.DATA_WIDTH(32), .MSB_FIRST(1), .CLK_FREQ(CLK)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int div);
        rx_line = 1'b0;
        tick(div);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            tick(div);
        end
        rx_line = stop;
        tick(div);
        rx_line = 1'b1;
    endtask

    // Sends four bytes in order and queues the word each DUT should show
    task automatic send_word(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3,
                             input logic [31:0] exp0, input logic [31:0] exp1,
                             input int div);
        q0.push_back(exp0);
        q1.push_back(exp1);
        send_byte(b0, 1'b1, div);
        send_byte(b1, 1'b1, div);
        send_byte(b2, 1'b1, div);
        send_byte(b3, 1'b1, div);
        tick(2 * div);
    endtask

    task automatic snap();
        rx_snap0 = rx_cnt0; rx_snap1 = rx_cnt1;
        fe_snap0 = fe_cnt0; fe_snap1 = fe_cnt1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (bus0.rx_done) begin
            rx_cnt0++;
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL rx_done0: strobe with no word expected, data %h", bus0.data);
            end else chk("data0", bus0.data, q0.pop_front());
        end
        if (bus1.rx_done) begin
            rx_cnt1++;
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL rx_done1: strobe with no word expected, data %h", bus1.data);
            end else chk("data1", bus1.data, q1.pop_front());
        end
        if (bus0.frame_error) fe_cnt0++;
        if (bus1.frame_error) fe_cnt1++;
        if (bus0.rx_done || bus0.frame_error)
            chk("done_fe_excl0", 32'(bus0.rx_done & bus0.frame_error), 32'd0);
        if (bus1.rx_done || bus1.frame_error)
            chk("done_fe_excl1", 32'(bus1.rx_done & bus1.frame_error), 32'd0);
    end

    initial begin
        tick(5);
        chk("rst_data0", bus0.data, 32'h0);
        chk("rst_data1", bus1.data, 32'h0);
        chk("rst_done0", 32'(bus0.rx_done), 32'd0);
        chk("rst_fe0", 32'(bus0.frame_error), 32'd0);
        chk("rst_state0", 32'(bus0.uart_state), 32'd0);
        chk("rst_state1", 32'(bus1.uart_state), 32'd0);
        reset = 1'b0;
        tick(10);

        // Basic word at 115200
        snap();
        send_word(8'h67, 8'h45, 8'h23, 8'h01, 32'h01234567, 32'h67452301, B4);
        chk("w1_q0_empty", 32'(q0.size()), 32'd0);
        chk("w1_q1_empty", 32'(q1.size()), 32'd0);
        chk("w1_done_cnt0", 32'(rx_cnt0 - rx_snap0), 32'd1);
        chk("w1_done_cnt1", 32'(rx_cnt1 - rx_snap1), 32'd1);
        chk("w1_state0", 32'(bus0.uart_state), 32'd0);

        // Short low glitch is a false start
        snap();
        rx_line = 1'b0;
        tick(10);
        rx_line = 1'b1;
        tick(3 * B4);
        chk("gl_done", 32'(rx_cnt0 - rx_snap0), 32'd0);
        chk("gl_fe", 32'(fe_cnt0 - fe_snap0), 32'd0);
        chk("gl_state", 32'(bus0.uart_state), 32'd0);
        chk("gl_data0", bus0.data, 32'h01234567);

        // Bad stop on the second byte
        snap();
        send_byte(8'hAA, 1'b1, B4);
        send_byte(8'h55, 1'b0, B4);
        tick(2 * B4);
        chk("fe_cnt0", 32'(fe_cnt0 - fe_snap0), 32'd1);
        chk("fe_cnt1", 32'(fe_cnt1 - fe_snap1), 32'd1);
        chk("fe_done0", 32'(rx_cnt0 - rx_snap0), 32'd0);
        chk("fe_data0", bus0.data, 32'h01234567);
        chk("fe_data1", bus1.data, 32'h67452301);
        chk("fe_state0", 32'(bus0.uart_state), 32'd0);
        send_word(8'h78, 8'h56, 8'h34, 8'h12, 32'h12345678, 32'h78563412, B4);
        chk("fe_recover_q0", 32'(q0.size()), 32'd0);

        // Reset in the middle of the third byte
        send_byte(8'h11, 1'b1, B4);
        send_byte(8'h22, 1'b1, B4);
        rx_line = 1'b0;
        tick(3 * B4);
        reset = 1'b1;
        rx_line = 1'b1;
        tick(4);
        chk("mr_state0", 32'(bus0.uart_state), 32'd0);
        chk("mr_data0", bus0.data, 32'h0);
        reset = 1'b0;
        tick(10);
        baud = 3'd0;
        send_word(8'h89, 8'h67, 8'h45, 8'h23, 32'h23456789, 32'h89674523, B0);
        chk("mr_q0_empty", 32'(q0.size()), 32'd0);
        chk("mr_q1_empty", 32'(q1.size()), 32'd0);

        // Partial word followed by a long idle
        baud = 3'd4;
        snap();
        send_byte(8'h9A, 1'b1, B4);
        send_byte(8'hBC, 1'b1, B4);
        tick(15 * B4);
        chk("to_early_fe", 32'(fe_cnt0 - fe_snap0), 32'd0);
        tick(5 * B4);
`ifdef UART_DATA_RX_TIMEOUT_EN
        chk("to_fe0", 32'(fe_cnt0 - fe_snap0), 32'd1);
        chk("to_fe1", 32'(fe_cnt1 - fe_snap1), 32'd1);
        chk("to_state0", 32'(bus0.uart_state), 32'd0);
`else
        chk("to_fe0", 32'(fe_cnt0 - fe_snap0), 32'd0);
        chk("to_state0", 32'(bus0.uart_state), 32'd1);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(5);
`endif
        chk("to_done0", 32'(rx_cnt0 - rx_snap0), 32'd0);
        send_word(8'hDE, 8'hC0, 8'hAD, 8'h0B, 32'h0BADC0DE, 32'hDEC0AD0B, B4);
        chk("to_q0_empty", 32'(q0.size()), 32'd0);
        chk("to_q1_empty", 32'(q1.size()), 32'd0);
        chk("to_state_end", 32'(bus1.uart_state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
